// File: rtl/intersection_controller.sv
// Two-road intersection sequencer: NS main road held green by default, EW side
// road and a pedestrian walk phase served on request after a minimum NS green.
module intersection_controller #(
  parameter int TW       = 8,
  parameter int NS_MIN   = 8,
  parameter int EW_T     = 6,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    PED_WALK  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALL_RED_B = 3'd6
  } state_e;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  // Terminal timer values: a phase lasting N cycles exits when the timer reads N-1.
  localparam logic [TW-1:0] NS_MIN_LAST = TW'(NS_MIN - 1);
  localparam logic [TW-1:0] EW_LAST     = TW'(EW_T - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] WALK_LAST   = TW'(WALK_T - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_pending_q, ped_pending_d;

  // State register, phase timer and pedestrian latch, with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values and the order of statements cannot create races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= NS_GREEN;
      timer_q       <= '0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Next-state decision, timer update and pedestrian latch update.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    ped_pending_d = ped_pending_q;

    case (state_q)
      NS_GREEN: begin
        if (timer_q == NS_MIN_LAST && (ew_car || ped_pending_q)) begin
          state_d = NS_YELLOW;
        end
      end
      NS_YELLOW: begin
        if (timer_q == YELLOW_LAST) state_d = ALL_RED_A;
      end
      ALL_RED_A: begin
        if (timer_q == ALLRED_LAST) state_d = ped_pending_q ? PED_WALK : EW_GREEN;
      end
      PED_WALK: begin
        if (timer_q == WALK_LAST) state_d = ew_car ? EW_GREEN : NS_GREEN;
      end
      EW_GREEN: begin
        if (timer_q == EW_LAST) state_d = EW_YELLOW;
      end
      EW_YELLOW: begin
        if (timer_q == YELLOW_LAST) state_d = ALL_RED_B;
      end
      ALL_RED_B: begin
        if (timer_q == ALLRED_LAST) state_d = NS_GREEN;
      end
      default: state_d = NS_GREEN;
    endcase

    // Timer restarts on every phase change; NS green saturates so a late
    // request is honoured on the very next edge.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (!(state_q == NS_GREEN && timer_q == NS_MIN_LAST)) begin
      timer_d = timer_q + 1'b1;
    end

    // Entering the walk phase serves the request, even one arriving on that edge.
    if (state_d == PED_WALK && state_q != PED_WALK) begin
      ped_pending_d = 1'b0;
    end else if (ped_req) begin
      ped_pending_d = 1'b1;
    end
  end

  // Moore decode of the lamps straight from the state register.
  always_comb begin
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    walk     = 1'b0;
    case (state_q)
      NS_GREEN:  ns_light = LIGHT_GREEN;
      NS_YELLOW: ns_light = LIGHT_YELLOW;
      PED_WALK:  walk     = 1'b1;
      EW_GREEN:  ew_light = LIGHT_GREEN;
      EW_YELLOW: ew_light = LIGHT_YELLOW;
      default:   ;
    endcase
  end

  assign ped_wait = ped_pending_q;
  assign phase    = state_q;

endmodule
